// File: rtl/fft_cbfp_reorder_pkg.sv
// Shared constants, types and helpers for the CBFP reorder buffer.
package fft_reorder_pkg;

  localparam int unsigned LANES       = 16;
  localparam int unsigned IN_W        = 12;
  localparam int unsigned EXP_W       = 5;
  localparam int unsigned OUT_W       = 25;
  localparam int unsigned FRAME_BEATS = 32;

  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned BEAT_W = $clog2(FRAME_BEATS);
  localparam int unsigned PT_W   = LANE_W + BEAT_W;
  localparam int unsigned SH_MAX = OUT_W - 1;

  typedef enum logic {IDLE, READ} rd_state_t;

  typedef logic [LANES-1:0][IN_W-1:0]  in_beat_t;
  typedef logic [LANES-1:0][OUT_W-1:0] out_beat_t;

  // One stored input beat: samples plus the two half-beat exponents
  typedef struct packed {
    in_beat_t             re;
    in_beat_t             im;
    logic [EXP_W-1:0]     idx_l;
    logic [EXP_W-1:0]     idx_h;
  } beat_word_t;

  function automatic logic [PT_W-1:0] bitrev(input logic [PT_W-1:0] x);
    logic [PT_W-1:0] r;
    for (int i = 0; i < int'(PT_W); i++) r[i] = x[int'(PT_W)-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_cbfp_reorder_if.sv
// Input/output beat bundle between the CBFP stage, the reorder buffer and its consumer.
interface fft_cbfp_reorder_if;

  logic                                 val_in;
  fft_reorder_pkg::in_beat_t            re_in;
  fft_reorder_pkg::in_beat_t            im_in;
  logic [fft_reorder_pkg::EXP_W-1:0]    index_l;
  logic [fft_reorder_pkg::EXP_W-1:0]    index_h;
  logic                                 val_out;
  logic                                 sof_out;
  fft_reorder_pkg::out_beat_t           re_out;
  fft_reorder_pkg::out_beat_t           im_out;

  modport master (
    output val_in, re_in, im_in, index_l, index_h,
    input  val_out, sof_out, re_out, im_out
  );

  modport slave (
    input  val_in, re_in, im_in, index_l, index_h,
    output val_out, sof_out, re_out, im_out
  );

endinterface

// File: rtl/fft_cbfp_reorder_denorm.sv
// Per-sample denormalisation: left-align into OUT_W, then arithmetic shift by a saturated exponent.
module fft_denorm_shift
  import fft_reorder_pkg::*;
(
  input  logic [IN_W-1:0]  smp_i,
  input  logic [EXP_W-1:0] exp_i,
  output logic [OUT_W-1:0] res_c_o
);

  logic signed [OUT_W-1:0] ext_c;
  logic [EXP_W-1:0]        sh_c;

  always_comb begin
    ext_c   = {smp_i, {(OUT_W-IN_W){1'b0}}};
    sh_c    = (exp_i > EXP_W'(SH_MAX)) ? EXP_W'(SH_MAX) : exp_i;
    res_c_o = ext_c >>> sh_c;
  end

endmodule

// File: rtl/fft_cbfp_reorder.sv
// Ping-pong frame buffer that denormalises CBFP samples and replays them one beat per clock.
// Define REORDER_BITREV_EN for natural-order (bit-reversed read) output; otherwise storage order.
module fft_cbfp_reorder
  import fft_reorder_pkg::*;
(
  input logic               clk,
  input logic               rstn,
  fft_cbfp_reorder_if.slave bus
);

  beat_word_t       mem_q [2][FRAME_BEATS];
  logic [BEAT_W-1:0] wr_cnt_q;
  logic              wr_bank_q;
  logic [1:0]        full_q, full_d;
  rd_state_t         state_q;
  logic              rd_bank_q;
  logic [BEAT_W-1:0] ob_q;
  logic              val_out_q, sof_out_q;
  out_beat_t         re_out_q, im_out_q;

  logic wr_wrap_c, emit_c, last_c;
  logic [PT_W-1:0]   src_pt_c   [LANES];
  logic [BEAT_W-1:0] src_beat_c [LANES];
  logic [LANE_W-1:0] src_lane_c [LANES];
  logic [IN_W-1:0]   src_re_c   [LANES];
  logic [IN_W-1:0]   src_im_c   [LANES];
  logic [EXP_W-1:0]  src_exp_c  [LANES];
  logic [OUT_W-1:0]  dn_re_c    [LANES];
  logic [OUT_W-1:0]  dn_im_c    [LANES];

  assign wr_wrap_c = bus.val_in && (wr_cnt_q == BEAT_W'(FRAME_BEATS-1));
  assign emit_c    = (state_q == READ) || full_q[rd_bank_q];
  assign last_c    = emit_c && (ob_q == BEAT_W'(FRAME_BEATS-1));

  // Sample storage carries no reset; validity is tracked by full_q
  always_ff @(posedge clk) begin
    if (bus.val_in)
      mem_q[wr_bank_q][wr_cnt_q] <= '{re: bus.re_in, im: bus.im_in,
                                      idx_l: bus.index_l, idx_h: bus.index_h};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
    end else if (bus.val_in) begin
      wr_cnt_q <= wr_cnt_q + BEAT_W'(1);
      if (wr_wrap_c) wr_bank_q <= ~wr_bank_q;
    end
  end

  always_comb begin
    full_d = full_q;
    if (last_c)    full_d[rd_bank_q] = 1'b0;
    if (wr_wrap_c) full_d[wr_bank_q] = 1'b1;
  end

  // Each output lane picks its own source beat/lane; the exponent follows the source half
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
`ifdef REORDER_BITREV_EN
      src_pt_c[l] = bitrev({ob_q, LANE_W'(l)});
`else
      src_pt_c[l] = {ob_q, LANE_W'(l)};
`endif
      src_beat_c[l] = src_pt_c[l][PT_W-1:LANE_W];
      src_lane_c[l] = src_pt_c[l][LANE_W-1:0];
      src_re_c[l]   = mem_q[rd_bank_q][src_beat_c[l]].re[src_lane_c[l]];
      src_im_c[l]   = mem_q[rd_bank_q][src_beat_c[l]].im[src_lane_c[l]];
      src_exp_c[l]  = src_lane_c[l][LANE_W-1] ? mem_q[rd_bank_q][src_beat_c[l]].idx_h
                                              : mem_q[rd_bank_q][src_beat_c[l]].idx_l;
    end
  end

  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    fft_denorm_shift u_re (.smp_i(src_re_c[l]), .exp_i(src_exp_c[l]), .res_c_o(dn_re_c[l]));
    fft_denorm_shift u_im (.smp_i(src_im_c[l]), .exp_i(src_exp_c[l]), .res_c_o(dn_im_c[l]));
  end

  // Read FSM; IDLE with a full bank emits beat 0 straight away, READ keeps going across banks
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q    <= '0;
      state_q   <= IDLE;
      rd_bank_q <= 1'b0;
      ob_q      <= '0;
      val_out_q <= 1'b0;
      sof_out_q <= 1'b0;
      re_out_q  <= '0;
      im_out_q  <= '0;
    end else begin
      full_q    <= full_d;
      val_out_q <= emit_c;
      sof_out_q <= emit_c && (ob_q == '0);
      if (emit_c) begin
        ob_q <= ob_q + BEAT_W'(1);
        for (int l = 0; l < int'(LANES); l++) begin
          re_out_q[l] <= dn_re_c[l];
          im_out_q[l] <= dn_im_c[l];
        end
        if (last_c) begin
          rd_bank_q <= ~rd_bank_q;
          state_q   <= full_q[~rd_bank_q] ? READ : IDLE;
        end else begin
          state_q <= READ;
        end
      end
    end
  end

  assign bus.val_out = val_out_q;
  assign bus.sof_out = sof_out_q;
  assign bus.re_out  = re_out_q;
  assign bus.im_out  = im_out_q;

endmodule

// File: tb/tb_fft_cbfp_reorder.sv
// Self-checking bench for fft_cbfp_reorder: frame-level reference model plus directed literal checks.
module tb_fft_cbfp_reorder;
  import fft_reorder_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fft_cbfp_reorder_if bus();
  fft_cbfp_reorder dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    int        due;
    logic      sof;
    out_beat_t re;
    out_beat_t im;
  } exp_beat_t;

  exp_beat_t exq[$];
  int checks = 0, errors = 0;
  int edge_n = 0, last_due = -1, cap_edge = -1, sof_edge = -1, sof_cnt = 0, cap_ob = 0;
  int fr_cnt = 0;
  in_beat_t         fr_re [FRAME_BEATS];
  in_beat_t         fr_im [FRAME_BEATS];
  logic [EXP_W-1:0] fr_il [FRAME_BEATS];
  logic [EXP_W-1:0] fr_ih [FRAME_BEATS];
  out_beat_t        cap_re [FRAME_BEATS];
  out_beat_t        cap_im [FRAME_BEATS];

  initial forever @(posedge clk) edge_n++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic int bitrev9(int x);
    int r = 0;
    for (int i = 0; i < int'(PT_W); i++) r = (r << 1) | ((x >> i) & 1);
    return r;
  endfunction

  // Value-level denormalisation: scale up by 2^(OUT_W-IN_W), floor-divide by 2^min(e,OUT_W-1)
  function automatic logic [OUT_W-1:0] denorm(logic [IN_W-1:0] s, logic [EXP_W-1:0] e);
    int v, sh, r;
    v  = int'($signed(s));
    sh = (int'(e) > int'(OUT_W) - 1) ? int'(OUT_W) - 1 : int'(e);
    r  = (v * (1 << (OUT_W - IN_W))) >>> sh;
    return r[OUT_W-1:0];
  endfunction

  task automatic push_frame();
    exp_beat_t eb;
    int start, k, src, sb, sl;
    start = (cap_edge + 1 > last_due + 1) ? cap_edge + 1 : last_due + 1;
    for (int ob = 0; ob < int'(FRAME_BEATS); ob++) begin
      for (int ol = 0; ol < int'(LANES); ol++) begin
        k = ob * int'(LANES) + ol;
`ifdef REORDER_BITREV_EN
        src = bitrev9(k);
`else
        src = k;
`endif
        sb = src / int'(LANES);
        sl = src % int'(LANES);
        eb.re[ol] = denorm(fr_re[sb][sl], (sl < int'(LANES) / 2) ? fr_il[sb] : fr_ih[sb]);
        eb.im[ol] = denorm(fr_im[sb][sl], (sl < int'(LANES) / 2) ? fr_il[sb] : fr_ih[sb]);
      end
      eb.due = start + ob;
      eb.sof = (ob == 0);
      exq.push_back(eb);
    end
    last_due = start + int'(FRAME_BEATS) - 1;
  endtask

  task automatic send_beat(input int kind);
    in_beat_t re, im;
    logic [EXP_W-1:0] il, ih;
    @(negedge clk);
    for (int l = 0; l < int'(LANES); l++) begin
      case (kind)
        0:       begin re[l] = IN_W'(l);       im[l] = '0;               end
        1:       begin re[l] = 12'h7FF;        im[l] = 12'h7FF;          end
        2:       begin re[l] = 12'h800;        im[l] = 12'h7FF;          end
        default: begin re[l] = IN_W'($urandom); im[l] = IN_W'($urandom); end
      endcase
    end
    case (kind)
      0:       begin il = 5'd13; ih = 5'd13; end
      1:       begin il = 5'd0;  ih = 5'd24; end
      2:       begin il = 5'd13; ih = 5'd31; end
      default: begin il = EXP_W'($urandom_range(0, 31)); ih = EXP_W'($urandom_range(0, 31)); end
    endcase
    bus.val_in = 1'b1; bus.re_in = re; bus.im_in = im; bus.index_l = il; bus.index_h = ih;
    fr_re[fr_cnt] = re; fr_im[fr_cnt] = im; fr_il[fr_cnt] = il; fr_ih[fr_cnt] = ih;
    fr_cnt++;
    if (fr_cnt == int'(FRAME_BEATS)) begin
      cap_edge = edge_n + 1;
      push_frame();
      fr_cnt = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.val_in = 1'b0;
    end
  endtask

  task automatic send_frame(input int kind, input bit gaps);
    for (int b = 0; b < int'(FRAME_BEATS); b++) begin
      send_beat(kind);
      if (gaps && (b % 5 == 4) && b < int'(FRAME_BEATS) - 1) idle(3);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exq.size() > 0 && n < 300) begin
      idle(1);
      n++;
    end
    checks++;
    if (exq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats still pending, want 0", exq.size());
      exq.delete();
    end
    idle(3);
  endtask

  task automatic chk(input string nm, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    bus.val_in = 1'b0;
    exq.delete();
    fr_cnt = 0;
    last_due = -1;
    #1;
    chk("rst_async_val_out", longint'(bus.val_out), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  function automatic int count_val(input bit use_im, input logic [OUT_W-1:0] v);
    int c = 0;
    for (int b = 0; b < int'(FRAME_BEATS); b++)
      for (int l = 0; l < int'(LANES); l++)
        if ((use_im ? cap_im[b][l] : cap_re[b][l]) == v) c++;
    return c;
  endfunction

  // Cycle-by-cycle compare against the model's expected beat schedule
  initial forever begin
    exp_beat_t eb;
    logic exp_v;
    @(negedge clk);
    if (rstn) begin
      exp_v = (exq.size() > 0) && (exq[0].due == edge_n);
      checks++;
      if (bus.val_out !== exp_v) begin
        errors++;
        $display("FAIL val_out @edge %0d: got %b want %b", edge_n, bus.val_out, exp_v);
      end
      if (exp_v) begin
        eb = exq.pop_front();
        checks += 3;
        if (bus.sof_out !== eb.sof) begin
          errors++;
          $display("FAIL sof_out @edge %0d: got %b want %b", edge_n, bus.sof_out, eb.sof);
        end
        if (bus.re_out !== eb.re) begin
          errors++;
          $display("FAIL re_out @edge %0d: got %h want %h", edge_n, bus.re_out, eb.re);
        end
        if (bus.im_out !== eb.im) begin
          errors++;
          $display("FAIL im_out @edge %0d: got %h want %h", edge_n, bus.im_out, eb.im);
        end
      end
      if (bus.val_out === 1'b1) begin
        if (bus.sof_out === 1'b1) begin
          cap_ob = 0;
          sof_cnt++;
          sof_edge = edge_n;
        end
        if (cap_ob < int'(FRAME_BEATS)) begin
          cap_re[cap_ob] = bus.re_out;
          cap_im[cap_ob] = bus.im_out;
        end
        cap_ob++;
      end
    end
  end

  initial begin
    int s0;
    longint p1, p32, p5;
`ifdef REORDER_BITREV_EN
    p1 = 0; p32 = 8; p5 = 0;
`else
    p1 = 1; p32 = 0; p5 = 5;
`endif
    bus.val_in = 1'b0; bus.re_in = '0; bus.im_in = '0; bus.index_l = '0; bus.index_h = '0;
    repeat (3) @(negedge clk);
    chk("rst_val_out", longint'(bus.val_out), 0);
    chk("rst_sof_out", longint'(bus.sof_out), 0);
    chk("rst_re_out_zero", longint'(bus.re_out != '0), 0);
    chk("rst_im_out_zero", longint'(bus.im_out != '0), 0);
    rstn = 1'b1;
    idle(2);

    // Ramp frame, all exponents 13: output equals input value
    s0 = sof_cnt;
    send_frame(0, 1'b0);
    drain();
    chk("t1_latency", longint'(sof_edge), longint'(cap_edge + 1));
    chk("t1_sof_count", longint'(sof_cnt - s0), 1);
    chk("t1_point1", longint'(cap_re[0][1]), p1);
    chk("t1_point32", longint'(cap_re[2][0]), p32);
    chk("t1_point5", longint'(cap_re[0][5]), p5);

    // Exponent split between lane halves
    send_frame(1, 1'b0);
    drain();
    chk("t2_count_0ffe000", longint'(count_val(1'b0, 25'h0FFE000)), 256);
    chk("t2_count_zero", longint'(count_val(1'b0, 25'h0000000)), 256);

    // Negative sample and saturated shift
    send_frame(2, 1'b0);
    drain();
    chk("t3_count_1fff800", longint'(count_val(1'b0, 25'h1FFF800)), 256);
    chk("t3_count_1ffffff", longint'(count_val(1'b0, 25'h1FFFFFF)), 256);
    chk("t3_im_count_7ff", longint'(count_val(1'b1, 25'h00007FF)), 256);

    // Two frames back-to-back, continuous input
    s0 = sof_cnt;
    send_frame(3, 1'b0);
    send_frame(3, 1'b0);
    drain();
    chk("t4_sof_count", longint'(sof_cnt - s0), 2);

    // Input gaps: 3 idle cycles every 5 beats
    send_frame(0, 1'b1);
    drain();
    chk("t5_latency", longint'(sof_edge), longint'(cap_edge + 1));
    chk("t5_point5", longint'(cap_re[0][5]), p5);

    // Reset in the middle of an input frame, then a fresh frame
    s0 = sof_cnt;
    for (int b = 0; b < 20; b++) send_beat(3);
    do_reset();
    idle(2);
    send_frame(2, 1'b0);
    drain();
    chk("t6_sof_count", longint'(sof_cnt - s0), 1);
    chk("t6_count_1fff800", longint'(count_val(1'b0, 25'h1FFF800)), 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
